// File: rtl/thw_frame_pkg.sv
// Shared types for thw_frame_reader: the 3x2 thw frame, data width,
// FSM state encoding and the frame-to-serial-order helper.
package thw_frame_pkg;

    typedef logic thw_frame_t [3:1][2:1];

    localparam int DATA_BITS = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef THW_FRAME_READER_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } thw_rd_state_e;

    // Bit 0 is the first data bit on the wire.
    function automatic logic [DATA_BITS-1:0] frame_to_bits(thw_frame_t f);
        logic [DATA_BITS-1:0] b;
        b[0] = f[3][2];
        b[1] = f[3][1];
        b[2] = f[2][2];
        b[3] = f[2][1];
        b[4] = f[1][2];
        b[5] = f[1][1];
        return b;
    endfunction

endpackage

// File: rtl/thw_frame_reader_if.sv
// Valid/ready frame handshake between a thw-array producer and
// thw_frame_reader.
interface thw_frame_reader_if;
    import thw_frame_pkg::*;

    thw_frame_t in_frame;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_frame,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_frame,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/thw_frame_reader_bit_tick_gen.sv
// Bit-period divider: pulses tick on the last cycle of each serial
// bit and restarts from zero whenever clear is high.
module bit_tick_gen #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/thw_frame_reader.sv
// Serialises 3x2 thw frames (start, 6 data, optional even parity under
// THW_FRAME_READER_PARITY_EN, stop) from a one-entry holding register.
module thw_frame_reader
    import thw_frame_pkg::*;
#(
    parameter int BIT_CYCLES = 4,
    parameter int STOP_BITS  = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    thw_frame_reader_if.slave in_if,
    output logic             ser_out,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    if (BIT_CYCLES < 1) begin : g_bit_cycles_chk
        $error("thw_frame_reader: BIT_CYCLES must be >= 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_bits_chk
        $error("thw_frame_reader: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    thw_rd_state_e          state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   load;
    logic                   accept;
    logic                   tick;
    logic                   tick_clear;

    assign in_if.in_ready = !hold_full_q;
    assign accept         = in_if.in_valid && !hold_full_q;
    assign busy           = (state_q != ST_IDLE);
    assign frame_cnt      = cnt_q;

    // Every state starts its bit period from a fresh count.
    assign tick_clear = (state_d != state_q) || (state_q == ST_IDLE);

    bit_tick_gen #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(tick_clear),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef THW_FRAME_READER_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef THW_FRAME_READER_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        cnt_d     = cnt_q + CNT_W'(1);
                        // A pending frame follows with no idle bit.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
        if (load) begin
            data_d      = hold_q;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = frame_to_bits(in_if.in_frame);
            hold_full_d = 1'b1;
        end
    end

    always_comb begin
        ser_out = 1'b1;
        unique case (state_q)
            ST_START: ser_out = 1'b0;
            ST_DATA:  ser_out = data_q[bit_cnt_q];
`ifdef THW_FRAME_READER_PARITY_EN
            ST_PARITY: ser_out = ^data_q;
`endif
            default:  ser_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
